// File: rtl/reg_dump_tx_if.sv
// rtl/reg_dump_tx_if.sv - Handshake, register-read and serial signals of the register dump transmitter
//
// Signals:
//   start    request a full register dump (sampled only while idle)
//   rd_addr  read address pointer driven into the register file
//   rd_data  combinational read data returned for rd_addr
//   tx       serial line, idle high
//   busy     dump in progress
//   done     one-cycle pulse after the last stop bit of the dump
//
// Modports:
//   master   the dump engine (drives rd_addr, tx, busy, done)
//   slave    the environment (drives start and rd_data)

interface reg_dump_tx_if #(
    parameter int pw = 3
) ();
    logic          start;
    logic [pw-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx;
    logic          busy;
    logic          done;

    modport master (
        input  start,
        input  rd_data,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - Walks every register address and sends each byte as an even-parity UART frame
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  asynchronous, active-high reset
//   bus    reg_dump_tx_if.master: start, rd_addr, rd_data, tx, busy, done
//
// Frame per register: LOAD (1 cycle, tx high), start bit, 8 data bits LSB first,
// even parity bit, stop bit; every serial bit lasts BAUD_DIV cycles.

module reg_dump_tx #(
    parameter int pw       = 3,
    parameter int BAUD_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    reg_dump_tx_if.master bus
);

    localparam int            BW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [pw-1:0] IDX_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic [pw-1:0] idx;
    logic          done_q;
    logic          tx_c;

    logic baud_last;
    logic last_stop;

    assign baud_last = (baud_cnt == BAUD_MAX);
    // Final stop bit of the last register: the dump ends at this edge.
    assign last_stop = (state == STOP) && baud_last && (idx == IDX_MAX);

    always_comb begin
        state_next = state;
        tx_c       = 1'b1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx_c = 1'b0;
                if (baud_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_c = shift[0];
                if (baud_last && (bit_cnt == 3'd7)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                tx_c = parity;
                if (baud_last) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_next = (idx == IDX_MAX) ? IDLE : LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            idx      <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= last_stop;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (bus.start) begin
                        idx <= '0;
                    end
                end
                LOAD: begin
                    shift    <= bus.rd_data;
                    parity   <= ^bus.rd_data;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START, PARITY: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
                end
                DATA: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
                    if (baud_last) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
                    // Leaving the last register returns the pointer to 0, so
                    // idle and the next dump's LOAD both present address 0.
                    if (baud_last) begin
                        idx <= (idx == IDX_MAX) ? '0 : idx + pw'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.tx      = tx_c;
    assign bus.rd_addr = idx;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - Scoreboard testbench for reg_dump_tx (BAUD_DIV=4 and BAUD_DIV=1 instances)

module tb_reg_dump_tx;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    logic [7:0] regs4 [0:7];
    logic [7:0] regs1 [0:7];
    int q4[$];
    int q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_dump_tx_if #(.pw(3)) bus4 ();
    reg_dump_tx_if #(.pw(3)) bus1 ();

    assign bus4.rd_data = regs4[bus4.rd_addr];
    assign bus1.rd_data = regs1[bus1.rd_addr];

    reg_dump_tx #(.pw(3), .BAUD_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    reg_dump_tx #(.pw(3), .BAUD_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decodes frames on one serial line and compares them against its queue.
    task automatic monitor(input int d, input int b);
        logic       s [0:43];
        logic       prev_tx = 1'b1;
        logic [2:0] prev_addr = 3'd0;
        logic       cur;
        logic [2:0] ca;
        logic [2:0] load_addr;
        logic       abort;
        logic       hold_ok;
        logic [7:0] data;
        int         e;
        forever begin
            @(negedge clk);
            cur = (d == 0) ? bus4.tx : bus1.tx;
            ca  = (d == 0) ? bus4.rd_addr : bus1.rd_addr;
            if (mon_en && !reset && prev_tx && !cur) begin
                load_addr = prev_addr;
                s[0] = 1'b0;
                abort = 1'b0;
                for (int k = 1; k < 11 * b; k++) begin
                    @(negedge clk);
                    if (reset) abort = 1'b1;
                    s[k] = (d == 0) ? bus4.tx : bus1.tx;
                end
                if (!abort) begin
                    hold_ok = 1'b1;
                    for (int bit_i = 0; bit_i < 11; bit_i++)
                        for (int j = 0; j < b; j++)
                            if (s[bit_i * b + j] !== s[bit_i * b]) hold_ok = 1'b0;
                    for (int j = 0; j < 8; j++) data[j] = s[(j + 1) * b];
                    if ((d == 0 && q4.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        check($sformatf("unexpected_frame_d%0d", d), {24'd0, data}, 32'hFFFF_FFFF);
                    end else begin
                        e = (d == 0) ? q4.pop_front() : q1.pop_front();
                        check($sformatf("bit_hold_d%0d", d), {31'd0, hold_ok}, 32'd1);
                        check($sformatf("frame_addr_d%0d", d), {29'd0, load_addr}, e / 256);
                        check($sformatf("frame_data_d%0d", d), {24'd0, data}, e % 256);
                        check($sformatf("parity_bit_d%0d", d), {31'd0, s[9 * b]},
                              {31'd0, ^(8'(e % 256))});
                        check($sformatf("stop_bit_d%0d", d), {31'd0, s[10 * b]}, 32'd1);
                    end
                end
                cur = s[11 * b - 1];
                ca  = (d == 0) ? bus4.rd_addr : bus1.rd_addr;
            end
            prev_tx   = cur;
            prev_addr = ca;
        end
    endtask

    initial fork
        monitor(0, 4);
        monitor(1, 1);
    join_none

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int m;
        int dcnt;
        int dat;
        int bbad;
        int d1;
        int d2;

        regs4[0] = 8'hA5; regs4[1] = 8'h07; regs4[2] = 8'hFF; regs4[3] = 8'h00;
        regs4[4] = 8'h3C; regs4[5] = 8'h81; regs4[6] = 8'h5A; regs4[7] = 8'hC3;
        regs1[0] = 8'h01; regs1[1] = 8'h80; regs1[2] = 8'hFE; regs1[3] = 8'h7F;
        regs1[4] = 8'h55; regs1[5] = 8'hAA; regs1[6] = 8'h10; regs1[7] = 8'hE7;

        reset = 1'b1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, bus4.tx}, 32'd1);
        check("rst_busy", {31'd0, bus4.busy}, 32'd0);
        check("rst_done", {31'd0, bus4.done}, 32'd0);
        check("rst_addr", {29'd0, bus4.rd_addr}, 32'd0);
        check("rst_tx1", {31'd0, bus1.tx}, 32'd1);
        reset = 1'b0;

        // Reset while idle.
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("idle_rst_tx", {31'd0, bus4.tx}, 32'd1);
        check("idle_rst_busy", {31'd0, bus4.busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the DATA phase of register 2.
        @(posedge clk);
        #1 bus4.start = 1'b1;
        @(posedge clk);
        #1 bus4.start = 1'b0;
        repeat (105) @(posedge clk);
        #3;
        check("pre_rst_busy", {31'd0, bus4.busy}, 32'd1);
        check("pre_rst_addr", {29'd0, bus4.rd_addr}, 32'd2);
        reset = 1'b1;
        #1;
        check("data_rst_tx", {31'd0, bus4.tx}, 32'd1);
        check("data_rst_busy", {31'd0, bus4.busy}, 32'd0);
        check("data_rst_done", {31'd0, bus4.done}, 32'd0);
        check("data_rst_addr", {29'd0, bus4.rd_addr}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_tx", {31'd0, bus4.tx}, 32'd1);
        check("post_rst_busy", {31'd0, bus4.busy}, 32'd0);
        check("post_rst_addr", {29'd0, bus4.rd_addr}, 32'd0);

        // Full dump at BAUD_DIV=4 with a stray start during register 3.
        mon_en = 1'b1;
        @(posedge clk);
        #1 bus4.start = 1'b1;
        n = cyc;
        for (int a = 0; a < 8; a++) q4.push_back(a * 256 + int'(regs4[a]));
        dcnt = 0; dat = 0; bbad = 0;
        for (int i = 0; i < 375; i++) begin
            @(negedge clk);
            bus4.start = (cyc == n) || (cyc == n + 156);
            if (cyc == n + 1) begin
                check("load_tx", {31'd0, bus4.tx}, 32'd1);
                check("load_addr", {29'd0, bus4.rd_addr}, 32'd0);
                check("load_busy", {31'd0, bus4.busy}, 32'd1);
            end
            if (cyc == n + 2) check("first_start_bit", {31'd0, bus4.tx}, 32'd0);
            if (cyc >= n + 1 && cyc <= n + 360 && !bus4.busy) bbad++;
            if (cyc == n + 361) check("busy_on_done", {31'd0, bus4.busy}, 32'd0);
            if (bus4.done) begin
                dcnt++;
                dat = cyc;
            end
        end
        check("done_count", dcnt, 32'd1);
        check("done_cycle", dat, n + 361);
        check("busy_gaps", bbad, 32'd0);

        // Back-to-back dumps at BAUD_DIV=1 with start held high.
        @(posedge clk);
        #1 bus1.start = 1'b1;
        m = cyc;
        for (int r = 0; r < 2; r++)
            for (int a = 0; a < 8; a++) q1.push_back(a * 256 + int'(regs1[a]));
        dcnt = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (cyc >= m + 102) bus1.start = 1'b0;
            if (cyc == m + 97) check("b2b_busy_on_done", {31'd0, bus1.busy}, 32'd0);
            if (cyc == m + 98) begin
                check("b2b_reload_addr", {29'd0, bus1.rd_addr}, 32'd0);
                check("b2b_reload_tx", {31'd0, bus1.tx}, 32'd1);
                check("b2b_reload_busy", {31'd0, bus1.busy}, 32'd1);
            end
            if (cyc == m + 99) check("b2b_start_bit", {31'd0, bus1.tx}, 32'd0);
            if (bus1.done) begin
                dcnt++;
                if (dcnt == 1) d1 = cyc;
                else d2 = cyc;
            end
        end
        check("b2b_done_count", dcnt, 32'd2);
        check("b2b_done1_cycle", d1, m + 97);
        check("b2b_done2_cycle", d2, m + 194);
        check("b2b_idle_busy", {31'd0, bus1.busy}, 32'd0);

        repeat (20) @(posedge clk);
        check("q4_drained", q4.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Debug read-out initiator for the register file: on a start request it walks every register address through one read port and captures each byte.
- Each byte is sent on a single serial line as a UART-style frame with an even-parity bit.
- Sits beside the register file and drives one of its read address pointers. Data read at address 6 is whatever that port returns (the parity-flag substitution is passed through unchanged).

Parameters:
- pw, 3, address pointer width; registers dumped = 2**pw
- BAUD_DIV, 4, clock cycles per serial bit (legal range >= 1)

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a full dump; sampled only in IDLE
- rd_addr  output  pw  read address pointer to the register file
- rd_data  input  8  combinational read data returned for rd_addr
- tx  output  1  serial line, idle high
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses
- done  output  1  one-cycle pulse after the final stop bit of the last register

Behaviour:
- Reset (async, immediate, mid-operation included): state=IDLE, tx=1, busy=0, done=0, rd_addr=0. Bit counter, baud counter and shift register are cleared.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If start=1 at a posedge, go to LOAD with idx=0.
- LOAD (exactly 1 cycle):
  - rd_addr=idx.
  - At the edge, latch rd_data into the shift register and compute parity = XOR of all 8 bits.
  - Go to START.
- rd_addr always equals the current idx, including during transmission. The register file is only required to be valid in LOAD.
- START: tx=0 for BAUD_DIV cycles.
- DATA: 8 bits, LSB first, each held BAUD_DIV cycles.
- PARITY: tx=parity bit for BAUD_DIV cycles. Even parity, so ones in data plus parity is even.
- STOP: tx=1 for BAUD_DIV cycles. Then:
  - if idx < 2**pw-1: increment idx, go to LOAD;
  - else: go to IDLE, set done=1 for exactly one cycle, busy=0 in that same cycle.
- Latency:
  - tx first falls 2 edges after start is sampled.
  - Frame length is 11*BAUD_DIV cycles.
  - Full dump from LOAD entry to done is 2**pw*(1+11*BAUD_DIV) cycles.
- Between frames tx stays 1 during the LOAD cycle.
- start while busy is ignored; no queuing.
- start held high continuously: a new dump begins the cycle after done (IDLE samples start).
- Register writes during a dump are allowed. Each byte reflects the register contents in its own LOAD cycle.
- idx wraps only by returning to IDLE; no modulo counting past the last register.
- Baud counter counts 0..BAUD_DIV-1. With BAUD_DIV=1, every bit lasts one cycle.

Test Plan:
- Reset: assert reset mid-idle and mid-DATA. Required: tx=1, busy=0, done=0, rd_addr=0 immediately (no clock edge needed); after deassert, stays IDLE with no start.
- Single frame content (BAUD_DIV=4): reg0=0xA5, start pulse. Required: tx low 2 edges after start. Bit sequence 0, 1,0,1,0,0,1,0,1, 0, 1, each bit 4 cycles. rd_addr=0 in LOAD.
- Parity check: reg1=0x07 -> parity bit 1; reg2=0xFF -> parity bit 0; reg3=0x00 -> parity bit 0. Scoreboard decodes all 8 frames and matches register contents, address order 0..7.
- Timing (BAUD_DIV=4, pw=3): start at cycle N. Required: done high exactly at cycle N+1+8*45, for one cycle; busy high throughout the dump, low on the done cycle.
- Start while busy: pulse start during the frame for reg 3. Required: no restart, frame order unchanged, single done pulse.
- Back-to-back (BAUD_DIV=1, start held high): required 12 cycles per register; a second dump starts the cycle after done with rd_addr=0 and tx falling one edge later.
